// File: rtl/tft_spi_word_serializer.sv
// Shifts one 16-bit word plus its RS flag out on a 4-wire, mode-0 SPI bus, or idles
// the bus for one word time on a delay slot. Both slot kinds take 33*CLK_DIV+1 cycles.
module tft_spi_word_serializer #(
   parameter int CLK_DIV   = 4,
   parameter int WORD_BITS = 16
) (
   input  logic                 CLK,
   input  logic                 RSTn,
   input  logic [WORD_BITS-1:0] Data,
   input  logic                 RS,
   input  logic                 CS,
   input  logic                 Start,
   output logic                 Ready,
   output logic                 Done,
   output logic                 SCK,
   output logic                 MOSI,
   output logic                 TFT_RS,
   output logic                 TFT_CS
);

   localparam int DIV_W = 8;
   localparam int BIT_W = $clog2(WORD_BITS);
   localparam int DLY_W = $clog2((2 * WORD_BITS + 1) * 255);
   localparam int DELAY_LEN = (2 * WORD_BITS + 1) * CLK_DIV;

   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_TOP    = BIT_W'(WORD_BITS - 1);
   localparam logic [DLY_W-1:0] DELAY_LAST = DLY_W'(DELAY_LEN - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      HOLD,
      DELAY
   } state_t;

   state_t               state_reg;
   logic [DIV_W-1:0]     div_reg;
   logic [BIT_W-1:0]     bit_reg;
   logic [DLY_W-1:0]     delay_reg;
   logic [WORD_BITS-1:0] shift_reg;
   logic [WORD_BITS-1:0] shift_next;
   logic                 ready_reg;
   logic                 done_reg;
   logic                 sck_reg;
   logic                 mosi_reg;
   logic                 tft_rs_reg;
   logic                 tft_cs_reg;

   // Rotate left so the next bit to send always sits at the MSB.
   assign shift_next[0] = shift_reg[WORD_BITS-1];
   generate
      for (genvar gi = 1; gi < WORD_BITS; gi++) begin : g_shift
         assign shift_next[gi] = shift_reg[gi-1];
      end
   endgenerate

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_reg  <= IDLE;
         div_reg    <= '0;
         bit_reg    <= '0;
         delay_reg  <= '0;
         shift_reg  <= '0;
         ready_reg  <= 1'b0;
         done_reg   <= 1'b0;
         sck_reg    <= 1'b0;
         mosi_reg   <= 1'b0;
         tft_rs_reg <= 1'b0;
         tft_cs_reg <= 1'b1;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               ready_reg <= 1'b1;
               if (Start && ready_reg) begin
                  ready_reg <= 1'b0;
                  div_reg   <= '0;
                  bit_reg   <= BIT_TOP;
                  delay_reg <= '0;
                  shift_reg <= Data;
                  sck_reg   <= 1'b0;
                  if (!CS) begin
                     state_reg  <= SHIFT;
                     tft_cs_reg <= 1'b0;
                     tft_rs_reg <= RS;
                     mosi_reg   <= Data[WORD_BITS-1];
                  end else begin
                     // Delay slot: bus stays idle and TFT_RS keeps its last value.
                     state_reg  <= DELAY;
                     tft_cs_reg <= 1'b1;
                     mosi_reg   <= 1'b0;
                  end
               end
            end

            SHIFT: begin
               if (div_reg == DIV_LAST) begin
                  div_reg <= '0;
                  if (!sck_reg) begin
                     sck_reg <= 1'b1;
                  end else begin
                     // Falling SCK ends a bit; MOSI only moves here, while SCK is low.
                     sck_reg <= 1'b0;
                     if (bit_reg == '0) begin
                        state_reg  <= HOLD;
                        tft_cs_reg <= 1'b1;
                        mosi_reg   <= 1'b0;
                     end else begin
                        bit_reg   <= bit_reg - 1'b1;
                        shift_reg <= shift_next;
                        mosi_reg  <= shift_next[WORD_BITS-1];
                     end
                  end
               end else begin
                  div_reg <= div_reg + 1'b1;
               end
            end

            HOLD: begin
               if (div_reg == DIV_LAST) begin
                  div_reg   <= '0;
                  state_reg <= IDLE;
                  done_reg  <= 1'b1;
                  ready_reg <= 1'b1;
               end else begin
                  div_reg <= div_reg + 1'b1;
               end
            end

            DELAY: begin
               if (delay_reg == DELAY_LAST) begin
                  delay_reg <= '0;
                  state_reg <= IDLE;
                  done_reg  <= 1'b1;
                  ready_reg <= 1'b1;
               end else begin
                  delay_reg <= delay_reg + 1'b1;
               end
            end

            default: begin
               state_reg  <= IDLE;
               tft_cs_reg <= 1'b1;
               sck_reg    <= 1'b0;
               mosi_reg   <= 1'b0;
            end
         endcase
      end
   end

   assign Ready  = ready_reg;
   assign Done   = done_reg;
   assign SCK    = sck_reg;
   assign MOSI   = mosi_reg;
   assign TFT_RS = tft_rs_reg;
   assign TFT_CS = tft_cs_reg;

endmodule

// File: doc/tft_spi_word_serializer.md
Name: tft_spi_word_serializer

Overview:
Serializes one 17-bit init/pixel slot (16-bit word plus RS flag) onto the TFT's 4-wire SPI bus. It sits directly downstream of the initialization word ROM, consuming its OutData/RS/CS outputs. A slot with CS=1 is a delay slot: the bus stays idle for exactly one word time. Done pulses once per slot and is used upstream to advance the ROM pointer, so each pointer step is one fixed-length time unit.

Parameters:
CLK_DIV, 4, system CLK cycles per SCK half-period; legal range 1..255.
WORD_BITS, 16, bits shifted per slot; fixed at 16 for this display.

Ports:
CLK  in  1  system clock, all logic on the rising edge.
RSTn  in  1  asynchronous, active-low reset.
Data  in  16  word to send (from ROM OutData).
RS  in  1  0 = command/index, 1 = parameter/data (from ROM RS).
CS  in  1  1 = delay slot, no transfer (from ROM CS).
Start  in  1  request to process the current Data/RS/CS slot.
Ready  out  1  serializer idle; Start is accepted when Start&Ready.
Done  out  1  one-cycle pulse when the slot completes.
SCK  out  1  SPI clock, mode 0 (idles low).
MOSI  out  1  SPI data, MSB first.
TFT_RS  out  1  display register-select line.
TFT_CS  out  1  display chip select, active low.

Behaviour:
- Reset (RSTn=0, asynchronous): SCK=0, MOSI=0, TFT_RS=0, TFT_CS=1, Ready=0, Done=0, FSM=IDLE, all counters cleared.
- Ready rises on the first CLK edge after RSTn deasserts.
- FSM states and transitions:
  - IDLE: Ready=1. Start&Ready at edge T0 latches Data, RS and CS, drives Ready=0, then:
    - goes to SHIFT if latched CS=0;
    - goes to DELAY if latched CS=1.
  - SHIFT, from cycle T0+1:
    - TFT_CS=0, TFT_RS=latched RS, MOSI=bit15.
    - Each bit lasts 2*CLK_DIV cycles: SCK low for CLK_DIV cycles, then high for CLK_DIV cycles.
    - MOSI changes only while SCK is low, at the start of the next bit.
    - After 16 bits (32*CLK_DIV cycles) go to HOLD with SCK=0.
  - HOLD: TFT_CS=1, MOSI=0 for CLK_DIV cycles, then go to IDLE.
  - DELAY:
    - TFT_CS=1, SCK=0, MOSI=0.
    - TFT_RS holds its previous value.
    - Lasts 33*CLK_DIV cycles, then go to IDLE.
- Completion: on IDLE re-entry, at cycle T0+1+33*CLK_DIV, Done=1 for one cycle and Ready=1 in the same cycle.
  - A Start present in that cycle is accepted immediately.
  - Slot period is therefore 33*CLK_DIV+1 cycles (133 at default) for both transfer and delay slots.
- Inputs: Data/RS/CS changes after acceptance are ignored. Start while Ready=0 is ignored; it is not queued.
- Counters:
  - Divider counts 0..CLK_DIV-1 and wraps.
  - Bit counter counts 15 down to 0.
  - Delay counter is sized for 33*255.
  - No overflow is possible within the legal range.
- Reset mid-slot: outputs go to reset values immediately. The partial word is abandoned and no Done is issued.
- TFT_CS is never low while the FSM is in DELAY or IDLE.
- SCK produces exactly 16 rising edges per transfer slot and none in a delay slot.

Test Plan:
1. Reset: hold RSTn=0 with Start=1 -> TFT_CS=1, SCK=0, Ready=0, Done=0. After release, Ready=1 next edge.
2. Command slot: CLK_DIV=4, Data=0x0010, RS=0, CS=0.
   - MOSI sampled at the 16 SCK rising edges reads 0x0010.
   - TFT_RS=0 and TFT_CS low for exactly 128 cycles.
   - Done at T0+133.
3. Data slot: Data=0xA5C3, RS=1 -> bits read 0xA5C3 and TFT_RS=1. Change Data to 0xFFFF mid-shift -> captured word is still 0xA5C3.
4. Delay slot: CS=1, Data=0x1234 -> zero SCK edges, TFT_CS=1 throughout, Done at T0+133.
5. Back-to-back: Start held high for 3 slots (CS=0,1,0):
   - acceptances exactly 133 cycles apart;
   - TFT_CS high at least 4 cycles between the two transfers;
   - three Done pulses.
6. Abort: RSTn low after 5 bits -> TFT_CS=1 asynchronously and no Done. After release, a new 0x0022 slot serializes correctly. Repeat with CLK_DIV=1 -> slot period 34 cycles.
